// File: rtl/pitch_height_tracker.sv
// Pitch height tracker: Schmitt zero-crossing period measurement averaged over PERIODS periods.
// Optional `PITCH_SMOOTH_EN averages each new height with the previous one.
module pitch_height_tracker #(
  parameter int DATA_W     = 12,
  parameter int HEIGHT_W   = 10,
  parameter int PERIODS    = 4,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 1023,
  parameter int HYST       = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mic_valid,
  input  logic [DATA_W-1:0]   mic_data,
  output logic [HEIGHT_W-1:0] height,
  output logic                height_valid,
  output logic                voiced
);
  localparam int CW    = $clog2(MAX_PERIOD + 1);
  localparam int LOG2P = $clog2(PERIODS);
  localparam int AW    = CW + LOG2P;
  localparam int NW    = $clog2(PERIODS + 1);
  localparam int MID   = 2 ** (DATA_W - 1);
  localparam logic [DATA_W:0]     HI_TH  = (DATA_W+1)'(MID + HYST);
  localparam logic [DATA_W:0]     LO_TH  = (DATA_W+1)'(MID - HYST);
  localparam logic [CW-1:0]       MAX_P  = CW'(MAX_PERIOD);
  localparam logic [CW-1:0]       MIN_P  = CW'(MIN_PERIOD);
  localparam logic [NW-1:0]       N_DONE = NW'(PERIODS);
  localparam logic [HEIGHT_W-1:0] H_MAX  = '1;

  typedef enum logic [1:0] {SEEK, MEASURE, UPDATE} state_t;

  function automatic logic [HEIGHT_W-1:0] sat_height(input logic [CW-1:0] v);
    logic [CW+HEIGHT_W-1:0] w;
    w = (CW+HEIGHT_W)'(v);
    sat_height = (w > (CW+HEIGHT_W)'(H_MAX)) ? H_MAX : HEIGHT_W'(w);
  endfunction

  state_t state, state_nx;
  logic hi, hi_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc, avg;
  logic [AW-1:0] acc, acc_nx;
  logic [NW-1:0] n, n_nx;
  logic [HEIGHT_W-1:0] raw, height_upd, height_nx;
  logic height_valid_nx, voiced_nx;
  logic rise, fall, is_edge, sat_hit, p_ok;

  always_comb begin
    rise    = ({1'b0, mic_data} >= HI_TH);
    fall    = ({1'b0, mic_data} <= LO_TH);
    is_edge = mic_valid && !hi && rise;
    // cnt_inc is the period P seen by an edge on this sample, already saturated
    cnt_inc = (cnt == MAX_P) ? cnt : cnt + CW'(1);
    sat_hit = mic_valid && !is_edge && (cnt_inc == MAX_P);
    p_ok    = (cnt_inc >= MIN_P);
    avg     = CW'(acc >> LOG2P);
    raw     = sat_height(MAX_P - avg);
  end

`ifdef PITCH_SMOOTH_EN
  logic [HEIGHT_W:0] smooth_sum;
  always_comb begin
    smooth_sum = {1'b0, height} + {1'b0, raw};
    height_upd = voiced ? HEIGHT_W'(smooth_sum >> 1) : raw;
  end
`else
  assign height_upd = raw;
`endif

  always_comb begin
    state_nx        = state;
    hi_nx           = hi;
    cnt_nx          = cnt;
    acc_nx          = acc;
    n_nx            = n;
    height_nx       = height;
    height_valid_nx = 1'b0;
    voiced_nx       = voiced;
    if (mic_valid) begin
      if (!hi && rise)     hi_nx = 1'b1;
      else if (hi && fall) hi_nx = 1'b0;
      cnt_nx = is_edge ? '0 : cnt_inc;
    end
    case (state)
      SEEK: begin
        acc_nx = '0;
        n_nx   = '0;
        if (is_edge) state_nx = MEASURE;
      end
      MEASURE: begin
        if (is_edge) begin
          if (p_ok) begin
            acc_nx = acc + AW'(cnt_inc);
            n_nx   = n + NW'(1);
            if (n + NW'(1) == N_DONE) state_nx = UPDATE;
          end else begin
            acc_nx = '0;
            n_nx   = '0;
          end
        end else if (sat_hit) begin
          state_nx  = SEEK;
          voiced_nx = 1'b0;
          acc_nx    = '0;
          n_nx      = '0;
        end
      end
      UPDATE: begin
        height_nx       = height_upd;
        height_valid_nx = 1'b1;
        voiced_nx       = 1'b1;
        acc_nx          = '0;
        n_nx            = '0;
        state_nx        = MEASURE;
        // An edge landing in the result cycle starts the next average
        if (is_edge && p_ok) begin
          acc_nx = AW'(cnt_inc);
          n_nx   = NW'(1);
          if (N_DONE == NW'(1)) state_nx = UPDATE;
        end
      end
      default: state_nx = SEEK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SEEK;
      hi           <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      n            <= '0;
      height       <= '0;
      height_valid <= 1'b0;
      voiced       <= 1'b0;
    end else begin
      state        <= state_nx;
      hi           <= hi_nx;
      cnt          <= cnt_nx;
      acc          <= acc_nx;
      n            <= n_nx;
      height       <= height_nx;
      height_valid <= height_valid_nx;
      voiced       <= voiced_nx;
    end
  end
endmodule

// File: doc/pitch_height_tracker.md
# pitch_height_tracker

Parametrised successor to `get_height`. It turns a stream of mono microphone samples into a bar height for the pitch game, using hysteretic zero-crossing period measurement averaged over several periods instead of a fixed 64-point FFT. It sits between the mic sample front-end and the game/render logic. It is generalised in sample width, averaging depth, period limits and output width, and adds a `voiced` status that the FFT block lacks.

## Interface
Parameters:
- `DATA_W`, 12: mic sample width; samples are unsigned offset-binary, midscale `MID = 2^(DATA_W-1)`.
- `HEIGHT_W`, 10: height output width.
- `PERIODS`, 4: number of periods averaged per result; power of two, ≥ 1.
- `MIN_PERIOD`, 8: shortest accepted period, in samples.
- `MAX_PERIOD`, 1023: longest accepted period, in samples; must be < `2^HEIGHT_W` × 2.
- `HYST`, 64: Schmitt hysteresis half-width, in LSBs.

Ports:
- `clk` in, 1: single system clock.
- `reset` in, 1: synchronous, active-high.
- `mic_valid` in, 1: `mic_data` is accepted on a rising edge of `clk` where this is 1.
- `mic_data` in, `DATA_W`: sample.
- `height` out, `HEIGHT_W`: registered pitch height; higher pitch gives a larger value.
- `height_valid` out, 1: one-cycle pulse when `height` updates.
- `voiced` out, 1: level signal; 1 while a periodic signal is being tracked.

## Operation
- **Schmitt comparator**, state LOW/HIGH, evaluated only on accepted samples:
  - LOW→HIGH when `mic_data >= MID+HYST`.
  - HIGH→LOW when `mic_data <= MID-HYST`.
  - A LOW→HIGH transition marks that sample as an *edge sample*.
- **Period counter**:
  - Increments on every accepted sample and saturates at `MAX_PERIOD`.
  - On an edge sample it is captured as period P (samples since the previous edge sample, that sample inclusive) and reloads to 0.
- **FSM states and transitions**:
  - SEEK: waits for the first edge sample, then goes to MEASURE. The accumulator and period count are cleared.
  - MEASURE, on an edge sample:
    - If `MIN_PERIOD ≤ P ≤ MAX_PERIOD`: `acc += P`, `n += 1`.
    - Otherwise: clear `acc` and `n`, and stay in MEASURE (the edge still restarts the counter).
    - When `n` reaches `PERIODS`, go to UPDATE.
  - MEASURE, if the counter reaches `MAX_PERIOD` with no edge: go to SEEK and clear `voiced`; `height` holds.
  - UPDATE (1 cycle):
    - `avg = acc >> log2(PERIODS)`.
    - `raw = sat_HEIGHT_W(MAX_PERIOD − avg)`.
    - Register `height`, pulse `height_valid`, set `voiced`, clear `acc` and `n`, return to MEASURE.
- **Arithmetic**:
  - `acc` width is `clog2(MAX_PERIOD+1) + log2(PERIODS)`; it never overflows.
  - The subtraction is unsigned and is never negative because `avg ≤ MAX_PERIOD`.
  - Saturation clamps to `2^HEIGHT_W − 1`.
- **Continuity**: samples continue to be accepted and counted during UPDATE, so no edge is lost.

## Timing
- **Reset values**:
  - `height` = 0, `height_valid` = 0, `voiced` = 0.
  - FSM in SEEK, Schmitt LOW, all counters and `acc` = 0.
- **Latency**: the completing edge sample is accepted on edge t, UPDATE runs on edge t+1, and `height`/`height_valid` are visible after edge t+1. That is one cycle after acceptance.
- **`height_valid`**: high for exactly one cycle per result. It is never high while in SEEK.
- **`voiced` clearing**: `voiced` falls on the edge where the counter hits `MAX_PERIOD` in MEASURE.
- **Simultaneous events**:
  - An edge sample in the same cycle as counter saturation counts as an edge with `P = MAX_PERIOD`, which is accepted.
  - `reset` overrides `mic_valid`.
- **Reset mid-measurement**: returns to reset values on the next edge, and any partial `acc` is discarded.
- **Gaps in `mic_valid`**: no effect on counts; only accepted samples count.

## Configuration
- `PITCH_SMOOTH_EN` defined:
  - In UPDATE, `height <= (height + raw) >> 1`, using a `HEIGHT_W+1`-bit sum.
  - Exception: the first result after `voiced` was 0 loads `raw` directly.
- `PITCH_SMOOTH_EN` undefined: `height <= raw`, with no smoothing register path.

## Test plan
1. **Reset**: hold `reset` for 2 cycles with random `mic_data` → `height` = 0, `height_valid` = 0, `voiced` = 0 throughout, and for 3 cycles after release with `mic_valid` = 0.
2. **Square wave, period 16**: 8 samples at `MID+512`, then 8 at `MID−512`, `mic_valid` = 1 every cycle, default parameters.
   - After the first edge plus 4 periods: one `height_valid` pulse with `height` = 1007, and `voiced` = 1.
   - Pulses repeat every 64 samples.
3. **Sub-hysteresis noise**: samples within `MID±32` for 2000 samples → no `height_valid`, `voiced` = 0, `height` = 0.
4. **Out-of-range periods**:
   - Square wave of period 4 (below `MIN_PERIOD`) → no `height_valid`.
   - Switching to period 16 → the first pulse comes 4 valid periods after the switch.
5. **Loss of signal**: after test 2, hold `mic_data` = `MID` → `voiced` falls 1023 accepted samples after the last edge, and `height` holds 1007.
6. **Period change and smoothing**: period 16 then period 32, sampled every other cycle.
   - With `PITCH_SMOOTH_EN`: 1007, then 999.
   - Without it: 1007, then 991.
   - Assert `reset` midway through a measurement → outputs return to 0 on the next edge.
